fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: size, 16, data/address width in bits.
REQ-002 Parameter: RESET_PC, 0, pc value loaded on reset.
REQ-003 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  fetch enable; low stops new requests.
REQ-006 Port: redirect  input  1  branch/jump redirect strobe.
REQ-007 Port: redirect_pc  input  size  redirect target address.
REQ-008 Port: imem_req  output  1  instruction-memory request.
REQ-009 Port: imem_addr  output  size  request address.
REQ-010 Port: imem_ack  input  1  memory accepts and returns data in the same cycle.
REQ-011 Port: imem_rdata  input  size  instruction word, valid when imem_ack=1.
REQ-012 Port: instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-013 Port: instr_ready  input  1  downstream decode stage accepts instr.
REQ-014 Port: instr  output  size  fetched instruction word.
REQ-015 Port: instr_pc  output  size  address of instr.
REQ-016 Port: pc  output  size  current fetch address.

Function
REQ-017 FSM states SHALL be IDLE, REQ and HOLD.
REQ-018 IDLE: imem_req=0; SHALL go to REQ on the next edge when en=1.
REQ-019 REQ: imem_req=1 and imem_addr=pc; both SHALL remain stable until imem_ack=1, regardless of en.
REQ-020 On imem_ack=1 in REQ: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, next state HOLD.
REQ-021 pc increment SHALL be modulo 2^size (all-ones wraps to 0); word addressing, step 1.
REQ-022 HOLD: instr, instr_pc and instr_valid=1 SHALL stay stable until instr_ready=1.
REQ-023 On instr_ready=1 in HOLD: instr_valid<=0; next state REQ if en=1, else IDLE.
REQ-024 Transfer occurs only on cycles with instr_valid=1 and instr_ready=1; instr_ready while instr_valid=0 SHALL be ignored.
REQ-025 redirect=1 SHALL take priority in every state: pc<=redirect_pc, instr_valid<=0, next state REQ if en=1, else IDLE.
REQ-026 redirect in REQ with imem_ack=1 in the same cycle SHALL discard imem_rdata.
REQ-027 redirect in HOLD with instr_ready=1 in the same cycle SHALL count as a completed transfer; only the pc update and FSM move occur.
REQ-028 The memory protocol SHALL permit withdrawing imem_req without imem_ack; no outstanding request survives a redirect.
REQ-029 Steady-state throughput SHALL be one instruction per 2 cycles with imem_ack and instr_ready held high.
REQ-030 No combinational path SHALL exist from any input to instr_valid, instr or instr_pc.

Reset
REQ-031 On rst=1: pc=RESET_PC, state IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-032 rst SHALL override redirect, imem_ack and instr_ready in the same cycle; any in-flight fetch is dropped.

Structure
REQ-033 The shared package SHALL hold the 2-bit state encodings (IDLE=0, REQ=1, HOLD=2) and the default RESET_PC.
REQ-034 instr and instr_pc SHALL each be an instance of the team's register block (reset to 0, enable = capture strobe); pc and FSM stay inline.

Verification
REQ-035 Reset, then en=1, imem_ack=1, instr_ready=1 -> addresses 0,1,2 requested; instr_pc 0,1,2 delivered, one every 2 cycles.
REQ-036 imem_ack held low 3 cycles in REQ -> imem_req and imem_addr stable for all 4 cycles; capture on the 4th.
REQ-037 instr_ready low 5 cycles in HOLD -> instr=0xA5A5 and instr_valid=1 held unchanged; no new imem_req.
REQ-038 redirect to 0x0040 coinciding with imem_ack (rdata 0x1234) -> 0x1234 never appears valid; next imem_addr=0x0040.
REQ-039 pc=0xFFFF, acked fetch -> instr_pc=0xFFFF, next imem_addr=0x0000.
REQ-040 rst asserted in HOLD with instr_ready=1 -> next cycle instr_valid=0, instr=0, pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and reset defaults.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_unit_reg.sv
// Enable-gated data register with synchronous clear to zero.
module fetch_unit_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (en) data_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request one word, hold it for decode, repeat.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              size     = 16,
    parameter logic [size-1:0] RESET_PC = size'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            redirect,
    input  logic [size-1:0] redirect_pc,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [size-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [size-1:0] instr,
    output logic [size-1:0] instr_pc,
    output logic [size-1:0] pc
);

    fetch_state_e    state_d, state_q;
    logic [size-1:0] pc_d, pc_q;
    logic            valid_d, valid_q;
    logic            req_d, req_q;
    logic            capture;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    capture = 1'b1;
                    pc_d    = pc_q + size'(1);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = en ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Redirect wins everywhere: any acked data or held word is dropped.
        if (redirect) begin
            capture = 1'b0;
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = en ? REQ : IDLE;
        end
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    fetch_unit_reg #(.W(size)) u_instr_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (imem_rdata),
        .q   (instr)
    );

    fetch_unit_reg #(.W(size)) u_instr_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (pc_q),
        .q   (instr_pc)
    );

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule
